serial_link_credit_receiver: RTL
================================

// Module: serial_link_credit_receiver
// PURPOSE
//  Receive-side end of the serial-link credit flow control. Takes packets from the link ({data, credits, credits-only flag}),
//  forwards piggybacked credits to the local credit_synchronization unit, and buffers data in a NumCredits-deep queue.
//  Sends each downstream consumption back as a credit-release pulse for the local unit to return to the peer.
// PARAMETERS
//  data_t       logic           payload type
//  DataWidth    $bits(data_t)   payload width; overrides data_t when set
//  credit_t     logic           credit-count type; must hold 0..NumCredits
//  NumCredits   -1              queue depth == credits granted to peer; must be >=2 (init assertion)
// PORTS
//  clk_i                 in   1          clock
//  rst_i                 in   1          asynchronous active-high reset
//  recv_valid_i          in   1          link packet valid
//  recv_ready_o          out  1          link ready (constant 1 outside reset; credit protocol guarantees space)
//  recv_data_i           in   DataWidth  packet payload
//  recv_credits_i        in   credit_t   credits returned by peer, carried in packet
//  recv_credits_only_i   in   1          1: packet carries credits only, payload ignored
//  credits_received_o    out  credit_t   credits to add to local available counter
//  receive_cred_o        out  1          qualifies credits_received_o (one-cycle pulse)
//  data_o                out  DataWidth  head of receive queue
//  valid_o               out  1          queue non-empty
//  ready_i               in   1          downstream consumes head when valid_o & ready_i
//  cred_release_o        out  1          = valid_o & ready_i; one credit freed
//  occupancy_o           out  credit_t   entries currently stored
//  overflow_o            out  1          sticky: push into full queue without same-cycle pop
// BEHAVIOUR
//  Reset (async, active-high): queue empty, pointers 0, occupancy_o=0, valid_o=0, data_o='0, receive_cred_o=0,
//   credits_received_o=0, overflow_o=0, recv_ready_o=0 while rst_i is high. Reset mid-operation drops queue contents and pending credits.
//  Link handshake hs = recv_valid_i & recv_ready_o.
//  Credit path: on hs, register receive_cred_o<=1 and credits_received_o<=recv_credits_i. Latency is 1 cycle.
//   Pulse even when recv_credits_i==0. Otherwise receive_cred_o<=0 and credits_received_o holds its value.
//  Data path: push = hs & ~recv_credits_only_i. A credits-only packet never enters the queue.
//   Pushed word is visible on data_o/valid_o the cycle after the handshake. No combinational path from recv_* to data_o.
//  Pop = valid_o & ready_i. data_o is stable while valid_o & ~ready_i.
//  Occupancy: occ_d = occ_q + push - pop.
//   Full (occ==NumCredits) with push and pop: both happen, occ unchanged, no overflow.
//   Full with push and no pop: word dropped, state unchanged, overflow_o set until reset.
//   Empty with push: valid_o=1 next cycle. A pop is never issued when empty.
//  Pointers wrap from NumCredits-1 to 0. Non-power-of-two depth is supported via explicit compare, not bit truncation.
//  cred_release_o is combinational from valid_o & ready_i. It drives buffer_queue_out_val_i/rdy_i of the local synchronizer.
//  Assertions:
//   occupancy_o <= NumCredits.
//   No X on recv_credits_i when recv_valid_i is high.
//   Flag overflow_o rising (protocol violation by peer).
// STRUCTURE
//  serial_link_pkg: shared credit_t width helper (localparam/function returning $clog2(NumCredits+1)) and the link packet struct
//   {credits_only, credits, data}, shared with the transmit side.
//  Sub-module serial_link_credit_rx_fifo: the storage queue with registered output, async active-high reset,
//   full/empty/occupancy, and wrap logic. The top level holds the credit register, push qualification and overflow flag.
// TESTING
//  1. NumCredits=8: 8 data packets, recv_credits_i=0, ready_i=0
//     -> occupancy_o=8, valid_o=1, overflow_o=0, eight receive_cred_o pulses with credits_received_o=0.
//  2. Credits-only packet with recv_credits_i=5 on empty queue
//     -> receive_cred_o=1 next cycle with value 5; valid_o stays 0; occupancy_o stays 0.
//  3. Full queue (8); cycle N: push and ready_i=1
//     -> cred_release_o=1 in N, occupancy_o=8 in N+1, overflow_o=0, FIFO order preserved.
//  4. Full queue, push with ready_i=0
//     -> overflow_o=1 from next cycle and sticky; stored data unchanged.
//  5. Stream 20 words 0x00..0x13 with ready_i randomly toggled
//     -> output order 0x00..0x13, data_o stable while stalled, 20 cred_release_o pulses, wrap verified.
//  6. Assert rst_i asynchronously mid-stream with 3 words queued
//     -> valid_o, receive_cred_o and occupancy_o go 0 immediately; first push after release reads back correctly.

Source files
------------

// File: rtl/serial_link_pkg.sv
// rtl/serial_link_pkg.sv - shared types and helpers for the serial-link credit flow control
//
// Purpose: credit-counter width helper and the link packet layout, shared by the
//          transmit and receive ends of the serial link.
// Ports:   none (package).

package serial_link_pkg;

   // Default packet field widths used where the link packet is carried as a whole word.
   localparam int LinkDataWidth   = 8;
   localparam int LinkCreditWidth = 4;

   // Bits needed to hold any credit count in 0..num_credits inclusive.
   function automatic int credit_width(input int num_credits);
      return $clog2(num_credits + 1);
   endfunction

   typedef struct packed {
      logic                       credits_only;
      logic [LinkCreditWidth-1:0] credits;
      logic [LinkDataWidth-1:0]   data;
   } link_pkt_t;

endpackage

// File: rtl/serial_link_credit_rx_fifo.sv
// rtl/serial_link_credit_rx_fifo.sv - receive data queue with wrap, full/empty and occupancy
//
// Purpose: Depth-entry storage queue for received link words. Output is taken from
//          registered state only, so no input reaches data_o combinationally.
// Ports:
//   clk_i        in   1          clock
//   rst_i        in   1          asynchronous active-high reset
//   push_i       in   1          write request (ignored when full without a same-cycle pop)
//   data_i       in   DataWidth  word to write
//   pop_i        in   1          downstream ready; pops the head when valid_o is high
//   data_o       out  DataWidth  head of queue ('0 when empty)
//   valid_o      out  1          queue non-empty
//   full_o       out  1          queue holds Depth entries
//   occupancy_o  out  CntWidth   entries stored

module serial_link_credit_rx_fifo
   import serial_link_pkg::*;
#(
   parameter int DataWidth = 8,
   parameter int Depth     = 8,
   parameter int CntWidth  = credit_width(Depth)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 push_i,
   input  logic [DataWidth-1:0] data_i,
   input  logic                 pop_i,
   output logic [DataWidth-1:0] data_o,
   output logic                 valid_o,
   output logic                 full_o,
   output logic [CntWidth-1:0]  occupancy_o
);

   localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
   localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);
   localparam logic [CntWidth-1:0] FullCnt = CntWidth'(Depth);

   logic [DataWidth-1:0] mem [Depth];
   logic [PtrWidth-1:0]  wr_ptr_q;
   logic [PtrWidth-1:0]  rd_ptr_q;
   logic [CntWidth-1:0]  occ_q;
   logic                 do_push;
   logic                 do_pop;

   // Explicit compare so non-power-of-two depths wrap correctly.
   function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] ptr);
      return (ptr == LastPtr) ? '0 : ptr + PtrWidth'(1);
   endfunction

   assign valid_o     = (occ_q != '0);
   assign full_o      = (occ_q == FullCnt);
   assign occupancy_o = occ_q;
   assign do_pop      = valid_o & pop_i;
   // A pop in the same cycle frees the slot, so a full queue still accepts the push.
   assign do_push     = push_i & (~full_o | do_pop);
   assign data_o      = valid_o ? mem[rd_ptr_q] : '0;

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem[wr_ptr_q] <= data_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= next_ptr(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_q <= next_ptr(rd_ptr_q);
         end
         if (do_push && !do_pop) begin
            occ_q <= occ_q + CntWidth'(1);
         end else if (!do_push && do_pop) begin
            occ_q <= occ_q - CntWidth'(1);
         end
      end
   end

endmodule

// File: rtl/serial_link_credit_receiver.sv
// rtl/serial_link_credit_receiver.sv - receive end of the serial-link credit flow control
//
// Purpose: accepts link packets, forwards piggybacked credits to the local credit
//          synchronizer, queues payload words, and reports each downstream consumption
//          as a credit-release pulse.
// Ports:
//   clk_i                in   1          clock
//   rst_i                in   1          asynchronous active-high reset
//   recv_valid_i         in   1          link packet valid
//   recv_ready_o         out  1          link ready (1 whenever out of reset)
//   recv_data_i          in   DataWidth  packet payload
//   recv_credits_i       in   credit_t   credits returned by the peer
//   recv_credits_only_i  in   1          packet carries credits only
//   credits_received_o   out  credit_t   credits to add to the local available counter
//   receive_cred_o       out  1          one-cycle qualifier for credits_received_o
//   data_o               out  DataWidth  head of receive queue
//   valid_o              out  1          queue non-empty
//   ready_i              in   1          downstream consumes head
//   cred_release_o       out  1          one credit freed (valid_o & ready_i)
//   occupancy_o          out  credit_t   entries stored
//   overflow_o           out  1          sticky: push into full queue without a pop

module serial_link_credit_receiver
   import serial_link_pkg::*;
#(
   parameter type data_t     = logic,
   parameter int  DataWidth  = $bits(data_t),
   parameter type credit_t   = logic [3:0],
   parameter int  NumCredits = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 recv_valid_i,
   output logic                 recv_ready_o,
   input  logic [DataWidth-1:0] recv_data_i,
   input  credit_t              recv_credits_i,
   input  logic                 recv_credits_only_i,
   output credit_t              credits_received_o,
   output logic                 receive_cred_o,
   output logic [DataWidth-1:0] data_o,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic                 cred_release_o,
   output credit_t              occupancy_o,
   output logic                 overflow_o
);

   localparam int CntWidth = credit_width(NumCredits);

   if (NumCredits < 2) begin : g_bad_depth
      $error("serial_link_credit_receiver: NumCredits must be >= 2");
   end
   if ($bits(credit_t) < CntWidth) begin : g_bad_credit_t
      $error("serial_link_credit_receiver: credit_t cannot hold 0..NumCredits");
   end

   logic                hs;
   logic                push;
   logic                full;
   logic [CntWidth-1:0] occ_cnt;

   // The peer only sends what it holds credits for, so the link never needs to stall.
   assign recv_ready_o   = ~rst_i;
   assign hs             = recv_valid_i & recv_ready_o;
   assign push           = hs & ~recv_credits_only_i;
   assign cred_release_o = valid_o & ready_i;
   assign occupancy_o    = credit_t'(occ_cnt);

   serial_link_credit_rx_fifo #(
      .DataWidth (DataWidth),
      .Depth     (NumCredits),
      .CntWidth  (CntWidth)
   ) u_rx_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (push),
      .data_i      (recv_data_i),
      .pop_i       (ready_i),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .full_o      (full),
      .occupancy_o (occ_cnt)
   );

   // Every accepted packet pulses, even with zero credits, so the local unit sees each packet.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         receive_cred_o     <= 1'b0;
         credits_received_o <= '0;
         overflow_o         <= 1'b0;
      end else begin
         receive_cred_o <= hs;
         if (hs) begin
            credits_received_o <= recv_credits_i;
         end
         if (push && full && !cred_release_o) begin
            overflow_o <= 1'b1;
         end
      end
   end

   a_occ_bound: assert property (@(posedge clk_i) disable iff (rst_i)
      occ_cnt <= CntWidth'(NumCredits));

   a_credits_known: assert property (@(posedge clk_i) disable iff (rst_i)
      recv_valid_i |-> !$isunknown(recv_credits_i));

   c_overflow_rise: cover property (@(posedge clk_i) disable iff (rst_i)
      $rose(overflow_o));

endmodule
